// File: rtl/tuart_rx.sv
// tuart_rx: 8N1 UART receiver that groups bytes into SUMP-style commands.
// Short command: one byte with bit 7 clear.
// Long command: an opcode with bit 7 set, followed by four parameter bytes, LSB byte first.
module tuart_rx #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned WORD_BITS    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic [7:0]  opcode_o,
    output logic [31:0] data_o,
    output logic        exec_o
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF   = CLKS_PER_BIT / 2;
    localparam int unsigned BIT_W  = $clog2(WORD_BITS);
    localparam int unsigned BCNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    logic                 rx_meta_q, rx_s_q;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 fe_q, fe_d;
    logic                 byte_vld_q, byte_vld_d;
    logic                 ferr_q, ferr_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [7:0]           opc_q, opc_d;
    logic [31:0]          acc_q, acc_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [31:0]          data_q, data_d;
    logic                 exec_q, exec_d;

    // Bit FSM: start detection, mid-bit sampling, stop check and framing-error hold.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        fe_d       = fe_q;
        byte_vld_d = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                fe_d = 1'b0;
                if (!rx_s_q) begin
                    cnt_d   = CNT_W'(HALF - 1);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rx_s_q, shift_q[WORD_BITS-1:1]};
                    cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
                    if (bit_q == BIT_W'(WORD_BITS - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s_q) begin
                    // A line that recovers after a framing error yields no byte.
                    byte_vld_d = !fe_q;
                    fe_d       = 1'b0;
                    state_d    = S_IDLE;
                end else if (!fe_q) begin
                    fe_d   = 1'b1;
                    ferr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command assembly: the byte counter walks 0..4 for long commands.
    always_comb begin
        bcnt_d   = bcnt_q;
        opc_d    = opc_q;
        acc_d    = acc_q;
        opcode_d = opcode_q;
        data_d   = data_q;
        exec_d   = 1'b0;
        if (ferr_q) begin
            bcnt_d = '0;
        end else if (byte_vld_q) begin
            if (bcnt_q == '0) begin
                if (!shift_q[7]) begin
                    opcode_d = shift_q;
                    data_d   = '0;
                    exec_d   = 1'b1;
                end else begin
                    opc_d  = shift_q;
                    acc_d  = '0;
                    bcnt_d = BCNT_W'(1);
                end
            end else begin
                case (bcnt_q)
                    BCNT_W'(1): acc_d[7:0]   = shift_q;
                    BCNT_W'(2): acc_d[15:8]  = shift_q;
                    BCNT_W'(3): acc_d[23:16] = shift_q;
                    default:    acc_d[31:24] = shift_q;
                endcase
                if (bcnt_q == BCNT_W'(4)) begin
                    opcode_d = opc_q;
                    data_d   = acc_d;
                    exec_d   = 1'b1;
                    bcnt_d   = '0;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
        end
    end

    // State registers, including the two-flop input synchronizer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            fe_q       <= 1'b0;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            bcnt_q     <= '0;
            opc_q      <= '0;
            acc_q      <= '0;
            opcode_q   <= '0;
            data_q     <= '0;
            exec_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            fe_q       <= fe_d;
            byte_vld_q <= byte_vld_d;
            ferr_q     <= ferr_d;
            bcnt_q     <= bcnt_d;
            opc_q      <= opc_d;
            acc_q      <= acc_d;
            opcode_q   <= opcode_d;
            data_q     <= data_d;
            exec_q     <= exec_d;
        end
    end

    assign opcode_o = opcode_q;
    assign data_o   = data_q;
    assign exec_o   = exec_q;

endmodule

// File: tb/tb_tuart_rx.sv
// Directed bench for tuart_rx with CLKS_PER_BIT = 10.
module tb_tuart_rx;

    localparam int unsigned CPB = 10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_i  = 1'b1;
    logic [7:0]  opcode_o;
    logic [31:0] data_o;
    logic        exec_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_exec = 0;
    int exec_cyc = 0;
    int start_cyc = 0;
    int n0;
    logic [7:0]  last_op = '0;
    logic [31:0] last_data = '0;

    tuart_rx #(.CLKS_PER_BIT(CPB), .WORD_BITS(8)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rx_i     (rx_i),
        .opcode_o (opcode_o),
        .data_o   (data_o),
        .exec_o   (exec_o)
    );

    always #5 clk_i = ~clk_i;

    // Cycle counter and exec_o monitor, sampled away from the active edge.
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) begin
        if (exec_o === 1'b1) begin
            n_exec    = n_exec + 1;
            last_op   = opcode_o;
            last_data = data_o;
            exec_cyc  = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int cycles);
        rx_i = v;
        repeat (cycles) @(negedge clk_i);
    endtask

    // One 8N1 frame; stop_v = 0 produces a framing error.
    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        @(negedge clk_i);
        start_cyc = cyc;
        rx_i = 1'b0;
        repeat (CPB - 1) @(negedge clk_i);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_v, CPB);
        rx_i = 1'b1;
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_opcode", 32'(opcode_o), 32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_exec", 32'(exec_o), 32'h0);

        // Short commands
        send_byte(8'h00, 1'b1);
        hold(1'b1, 2 * CPB);
        chk("short0_count", 32'(n_exec), 32'd1);
        chk("short0_op", 32'(last_op), 32'h00);
        chk("short0_data", last_data, 32'h0);
        send_byte(8'h02, 1'b1);
        hold(1'b1, 2 * CPB);
        chk("short2_count", 32'(n_exec), 32'd2);
        chk("short2_op", 32'(last_op), 32'h02);
        chk("short2_data", last_data, 32'h0);

        // Long command, back-to-back frames
        n0 = n_exec;
        send_byte(8'h80, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
        chk("long_no_early_exec", 32'(n_exec), 32'(n0));
        send_byte(8'h40, 1'b1);
        hold(1'b1, 2 * CPB);
        chk("long_count", 32'(n_exec), 32'(n0 + 1));
        chk("long_op", 32'(last_op), 32'h80);
        chk("long_data", last_data, 32'h40302010);
        // Stop centre at ~9.5 bits (cycle 95 after the falling edge),
        // +2 synchronizer cycles = sample edge 97, exec rises on edge 98,
        // which is observed on the negedge where cyc has advanced by 99.
        chk("exec_latency", 32'(exec_cyc - start_cyc), 32'd99);

        // Glitch rejection
        n0 = n_exec;
        @(negedge clk_i);
        hold(1'b0, 3);
        hold(1'b1, 3 * CPB);
        chk("glitch_count", 32'(n_exec), 32'(n0));
        chk("glitch_op_hold", 32'(opcode_o), 32'h80);
        chk("glitch_data_hold", data_o, 32'h40302010);
        send_byte(8'h11, 1'b1);
        hold(1'b1, 2 * CPB);
        chk("post_glitch_count", 32'(n_exec), 32'(n0 + 1));
        chk("post_glitch_op", 32'(last_op), 32'h11);
        chk("post_glitch_data", last_data, 32'h0);

        // Framing error aborts a partial long command
        n0 = n_exec;
        send_byte(8'hC0, 1'b1);
        send_byte(8'h55, 1'b0);
        hold(1'b1, 2 * CPB);
        chk("ferr_no_exec", 32'(n_exec), 32'(n0));
        send_byte(8'h01, 1'b1);
        hold(1'b1, 2 * CPB);
        chk("ferr_next_count", 32'(n_exec), 32'(n0 + 1));
        chk("ferr_next_op", 32'(last_op), 32'h01);
        chk("ferr_next_data", last_data, 32'h0);

        // Reset in the middle of a long command
        n0 = n_exec;
        send_byte(8'h82, 1'b1);
        send_byte(8'hAA, 1'b1);
        hold(1'b1, CPB);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrst_op", 32'(opcode_o), 32'h0);
        chk("midrst_data", data_o, 32'h0);
        chk("midrst_exec", 32'(exec_o), 32'h0);
        send_byte(8'h03, 1'b1);
        hold(1'b1, 2 * CPB);
        chk("midrst_count", 32'(n_exec), 32'(n0 + 1));
        chk("midrst_next_op", 32'(last_op), 32'h03);
        chk("midrst_next_data", last_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
